// File: rtl/rr_issue_arbiter.sv
// -----------------------------------------------------------------------------
// rr_issue_arbiter
// Round-robin issue arbiter with a registered one-hot grant that holds until
// the downstream accepts it. Accept and re-arbitration share a cycle, so a
// continuously accepting consumer sees one grant per cycle with no bubbles.
//
// Optional feature (macro ARB_STARVE_PROTECT_EN): per-requester 8-bit
// saturating wait counters. Once any waiting requester reaches STARVE_LIMIT,
// the lowest-index such requester wins over the round-robin order.
//
// Parameters:
//   NUM_REQ      requester count (4, 8, 16, 32, 64)
//   IDX_W        index width, log2(NUM_REQ)+1 so NUM_REQ itself is encodable
//   STARVE_LIMIT wait-cycle threshold for starvation promotion (1..255)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ready        per-requester request, bit i for requester i
//   grant_accept downstream consumes the presented grant this cycle
//   grant        registered one-hot grant, or all-zero
//   granted      index of the set grant bit, NUM_REQ when none is set
//   grant_valid  grant register holds a live grant
// -----------------------------------------------------------------------------
module rr_issue_arbiter #(
    parameter int unsigned NUM_REQ      = 16,
    parameter int unsigned IDX_W        = 5,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] ready,
    input  logic               grant_accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   granted,
    output logic               grant_valid
);

    localparam int unsigned      PTR_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] NONE_IDX = IDX_W'(NUM_REQ);

    // Elaboration-time parameter legality checks
    if (NUM_REQ != 4 && NUM_REQ != 8 && NUM_REQ != 16 && NUM_REQ != 32 && NUM_REQ != 64) begin : g_bad_num_req
        $error("rr_issue_arbiter: NUM_REQ must be 4, 8, 16, 32 or 64");
    end
    if (IDX_W != PTR_W + 1) begin : g_bad_idx_w
        $error("rr_issue_arbiter: IDX_W must equal log2(NUM_REQ)+1");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
        $error("rr_issue_arbiter: STARVE_LIMIT must be in 1..255");
    end

    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_granted;
    logic               r_grant_valid;
    logic [PTR_W-1:0]   r_ptr;

    logic               w_loadable;
    logic               w_accept;
    logic [PTR_W-1:0]   w_ptr_eff;
    logic               w_rr_found;
    logic [PTR_W-1:0]   w_rr_idx;
    logic               w_win_found;
    logic [PTR_W-1:0]   w_win_idx;

    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [IDX_W-1:0]   w_granted_nxt;
    logic               w_valid_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;

    assign grant       = r_grant;
    assign granted     = r_granted;
    assign grant_valid = r_grant_valid;

    assign w_loadable = !r_grant_valid || grant_accept;
    assign w_accept   = r_grant_valid && grant_accept;

    // On an accept the search starts just past the winner, so the accepted
    // requester is last in order and cannot be regranted while others wait.
    assign w_ptr_eff = w_accept ? PTR_W'(r_granted[PTR_W-1:0] + PTR_W'(1)) : r_ptr;

    // Round-robin search: first ready requester at ptr, ptr+1, ... (mod NUM_REQ)
    always_comb begin : p_rr_search
        logic [PTR_W-1:0] probe;
        probe      = '0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = PTR_W'(w_ptr_eff + PTR_W'(k));
            if (!w_rr_found && ready[probe]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = probe;
            end
        end
    end

`ifdef ARB_STARVE_PROTECT_EN
    logic [7:0]         r_wait_cnt [NUM_REQ];
    logic               w_starve_found;
    logic [PTR_W-1:0]   w_starve_idx;

    // Wait counters: count cycles of unaccepted request, saturate at 255
    always_ff @(posedge clk or negedge rst_n) begin : p_wait_cnt
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!ready[i] || (w_accept && r_grant[i])) begin
                    r_wait_cnt[i] <= '0;
                end else if (r_wait_cnt[i] != 8'hFF) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Lowest-index starving requester; the one being accepted right now is
    // excluded so a long-held grant is not immediately handed back.
    always_comb begin : p_starve_search
        w_starve_found = 1'b0;
        w_starve_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_starve_found && ready[i] && !(w_accept && r_grant[i])
                && (r_wait_cnt[i] >= 8'(STARVE_LIMIT))) begin
                w_starve_found = 1'b1;
                w_starve_idx   = PTR_W'(i);
            end
        end
    end

    assign w_win_found = w_starve_found || w_rr_found;
    assign w_win_idx   = w_starve_found ? w_starve_idx : w_rr_idx;
`else
    assign w_win_found = w_rr_found;
    assign w_win_idx   = w_rr_idx;
`endif

    // Next-state: hold unless loadable; ptr moves only on a real accept
    always_comb begin : p_next
        w_grant_nxt   = r_grant;
        w_granted_nxt = r_granted;
        w_valid_nxt   = r_grant_valid;
        w_ptr_nxt     = r_ptr;
        if (w_accept) begin
            w_ptr_nxt = w_ptr_eff;
        end
        if (w_loadable) begin
            w_grant_nxt = '0;
            if (w_win_found) begin
                w_grant_nxt[w_win_idx] = 1'b1;
                w_granted_nxt          = IDX_W'(w_win_idx);
                w_valid_nxt            = 1'b1;
            end else begin
                w_granted_nxt = NONE_IDX;
                w_valid_nxt   = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            r_grant       <= '0;
            r_granted     <= NONE_IDX;
            r_grant_valid <= 1'b0;
            r_ptr         <= '0;
        end else begin
            r_grant       <= w_grant_nxt;
            r_granted     <= w_granted_nxt;
            r_grant_valid <= w_valid_nxt;
            r_ptr         <= w_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_issue_arbiter
// Directed scoreboard bench for rr_issue_arbiter (NUM_REQ=16). Each stimulus
// step pushes the hand-computed expected granted index for the cycle after
// its clock edge; a monitor pops and compares all three outputs every cycle.
// With ARB_STARVE_PROTECT_EN defined the DUT runs with STARVE_LIMIT=3 and an
// extra starvation sequence is driven.
// -----------------------------------------------------------------------------
module tb_rr_issue_arbiter;

    localparam int unsigned N  = 16;
    localparam int unsigned IW = 5;
`ifdef ARB_STARVE_PROTECT_EN
    localparam int unsigned SL = 3;
`else
    localparam int unsigned SL = 15;
`endif

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  ready;
    logic          grant_accept;
    logic [N-1:0]  grant;
    logic [IW-1:0] granted;
    logic          grant_valid;

    int n_checks;
    int n_errors;

    logic [IW-1:0] q_idx [$];
    string         q_tag [$];

    rr_issue_arbiter #(
        .NUM_REQ      (N),
        .IDX_W        (IW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ready        (ready),
        .grant_accept (grant_accept),
        .grant        (grant),
        .granted      (granted),
        .grant_valid  (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Expected {valid, granted, grant} for an expected index (N = no grant)
    function automatic logic [63:0] expect_vec(input logic [IW-1:0] e);
        logic [N-1:0] g;
        g = '0;
        if (e != IW'(N)) begin
            g[e[3:0]] = 1'b1;
            return 64'({1'b1, e, g});
        end
        return 64'({1'b0, e, g});
    endfunction

    // Monitor: compare outputs once per cycle, just after the active edge
    always @(posedge clk) begin
        logic [IW-1:0] e;
        string         t;
        #1;
        if (q_idx.size() > 0) begin
            e = q_idx.pop_front();
            t = q_tag.pop_front();
            check(t, 64'({grant_valid, granted, grant}), expect_vec(e));
        end
    end

    task automatic step(input logic [N-1:0] r, input logic a, input int exp_idx, input string tag);
        ready        = r;
        grant_accept = a;
        q_idx.push_back(IW'(exp_idx));
        q_tag.push_back(tag);
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        ready        = '0;
        grant_accept = 1'b0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_state", 64'({grant_valid, granted, grant}), expect_vec(IW'(N)));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Idle: no requests for three cycles
        for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, N, "idle");

        // Full load, accept every cycle: 0..15 then wrap to 0
        for (int i = 0; i <= 16; i++) step(16'hFFFF, 1'b1, i % 16, "full_rr");
        step(16'h0000, 1'b1, N, "full_rr_drain");

        // Return ptr to 0 through the 15 -> 0 wrap
        step(16'h8000, 1'b0, 15, "wrap_setup");
        step(16'h0000, 1'b1, N, "wrap_accept");

        // Hold without accept, then accept with a changed request set
        for (int i = 0; i < 5; i++) step(16'h0011, 1'b0, 0, "hold_0");
        step(16'h0010, 1'b1, 4, "accept_then_4");
        check("ptr_after_accept", 64'(dut.r_ptr), 64'd1);
        step(16'h0000, 1'b0, 4, "hold_ready_drop");
        step(16'h0000, 1'b1, N, "accept_4");
        step(16'h0000, 1'b1, N, "accept_ignored");
        step(16'h0021, 1'b0, 5, "ptr_unmoved");
        step(16'h0021, 1'b1, 0, "no_regrant");
        step(16'h0000, 1'b1, N, "drain_0");

        // ptr=15 with requesters 15 and 0 alternating
        step(16'h4000, 1'b0, 14, "alt_setup");
        step(16'h8001, 1'b1, 15, "alt_15a");
        step(16'h8001, 1'b1, 0,  "alt_0a");
        step(16'h8001, 1'b1, 15, "alt_15b");
        step(16'h8001, 1'b1, 0,  "alt_0b");
        step(16'h0000, 1'b1, N,  "alt_drain");

        // Async reset while a grant is held; ptr was 3 before reset
        step(16'h0004, 1'b0, 2,  "pre_rst_2");
        step(16'h0400, 1'b1, 10, "pre_rst_10");
        step(16'h0400, 1'b0, 10, "pre_rst_hold");
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 64'(grant), 64'd0);
        check("async_rst_granted", 64'(granted), 64'(N));
        check("async_rst_valid", 64'(grant_valid), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(16'h0401, 1'b0, 0, "post_rst_ptr0");

`ifdef ARB_STARVE_PROTECT_EN
        // Requester 9 joins behind a busy upper group; promoted on its 4th loadable cycle
        step(16'h0000, 1'b1, N,  "stv_drain");
        step(16'hFC00, 1'b0, 10, "stv_10");
        step(16'hFE00, 1'b1, 11, "stv_11");
        step(16'hFE00, 1'b1, 12, "stv_12");
        step(16'hFE00, 1'b1, 13, "stv_13");
        step(16'hFE00, 1'b1, 9,  "stv_9_promoted");
        step(16'hFE00, 1'b1, 10, "stv_10_promoted");
        step(16'h0000, 1'b1, N,  "stv_end");
`endif

        @(posedge clk);
        #3;
        check("scoreboard_drained", 64'(q_idx.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
